vio_ingress_decode: RTL and testbench

- Ingress stage of one vIO Switch port. It consumes the AXI4SR stream produced by a vFPGA's send gateway, with the route_id carried on tdest.
- Decodes receiver_id into a one-hot egress port select and locks it for the whole packet.
- Drops packets with malformed or out-of-range routes.
- Presents a registered, packet-atomic stream to the switch crossbar arbiter.

---
 rtl/vio_ingress_decode.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_vio_ingress_decode.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vio_ingress_decode.sv
// -----------------------------------------------------------------------------
// vio_ingress_decode
//
// Ingress stage of one vIO Switch port. Takes the AXI4SR stream from a vFPGA
// send gateway (route_id on tdest), checks the route on each packet header,
// decodes the receiver into a one-hot egress port select that is locked for
// the whole packet, silently drops malformed or out-of-range packets, and
// hands a registered, packet-atomic stream to the crossbar arbiter through a
// 2-entry skid buffer.
//
// route_id layout (tdest): [13:10] reserved (must be 0), [9:6] sender,
//                          [5:2] receiver, [1:0] flags (passed through).
//
// Optional feature: define VIO_SENDER_CHECK_EN to also reject headers whose
// sender field differs from s_axis_tid[3:0]; this adds the spoof_sticky port.
//
// Ports
//   aclk, aresetn      clock, synchronous active-low reset
//   s_axis_*           upstream stream (tvalid/tready/tdata/tkeep/tlast/tid/tdest)
//   m_axis_*           stream to crossbar (tvalid/tready/tdata/tkeep/tlast/tid)
//   m_port_sel         one-hot egress port of the beat at the output
//   m_route            latched route_id of the beat at the output
//   pkt_cnt, drop_cnt  saturating counts of forwarded / dropped packets
//   err_sticky         set on any drop, cleared by reset only
//   spoof_sticky       (VIO_SENDER_CHECK_EN only) set on a spoofed-sender drop
// -----------------------------------------------------------------------------
module vio_ingress_decode #(
  parameter int N_PORTS   = 11,
  parameter int DATA_BITS = 512,
  parameter int PID_BITS  = 6,
  parameter int CNT_BITS  = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [PID_BITS-1:0]    s_axis_tid,
  input  logic [13:0]            s_axis_tdest,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [PID_BITS-1:0]    m_axis_tid,
  output logic [N_PORTS-1:0]     m_port_sel,
  output logic [13:0]            m_route,
  output logic [CNT_BITS-1:0]    pkt_cnt,
  output logic [CNT_BITS-1:0]    drop_cnt,
  output logic                   err_sticky
`ifdef VIO_SENDER_CHECK_EN
  ,
  output logic                   spoof_sticky
`endif
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // One buffered beat; the routing side-band travels with its payload so it
  // stays aligned with the data during output stalls.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
    logic [PID_BITS-1:0]  tid;
    logic [N_PORTS-1:0]   port_sel;
    logic [13:0]          route;
  } beat_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [N_PORTS-1:0] r_port_sel;
  logic [13:0]        r_route;

  beat_t              r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [1:0]         w_count_n;
  logic               r_s_ready;

  logic [CNT_BITS-1:0] r_pkt_cnt;
  logic [CNT_BITS-1:0] r_drop_cnt;
  logic                r_err_sticky;

  logic               w_s_hs;
  logic               w_pop;
  logic               w_push;
  logic               w_pkt_evt;
  logic               w_drop_evt;
  beat_t              w_entry;
  beat_t              w_head;

  // ---------------------------------------------------------------------------
  // Header decode (only meaningful on a HEAD beat)
  // ---------------------------------------------------------------------------
  logic [3:0]         w_rsv;
  logic [3:0]         w_sender;
  logic [3:0]         w_receiver;
  logic               w_route_ok;
  logic               w_legal;
  logic [N_PORTS-1:0] w_dec_sel;

  assign w_rsv      = s_axis_tdest[13:10];
  assign w_sender   = s_axis_tdest[9:6];
  assign w_receiver = s_axis_tdest[5:2];

  assign w_route_ok = (w_rsv == 4'd0)
                   && ({1'b0, w_receiver} < 5'(N_PORTS))
                   && (w_receiver != w_sender);

`ifdef VIO_SENDER_CHECK_EN
  logic w_spoof;
  assign w_spoof = (w_sender != s_axis_tid[3:0]);
  assign w_legal = w_route_ok && !w_spoof;
`else
  assign w_legal = w_route_ok;
`endif

  always_comb begin
    w_dec_sel = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_dec_sel[i] = (w_receiver == 4'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign s_axis_tready = r_s_ready;
  assign w_s_hs        = s_axis_tvalid && r_s_ready;
  assign m_axis_tvalid = (r_count != 2'd0);
  assign w_pop         = m_axis_tvalid && m_axis_tready;

  // ---------------------------------------------------------------------------
  // FSM next state and buffer write request
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    w_state_n  = r_state;
    w_push     = 1'b0;
    w_pkt_evt  = 1'b0;
    w_drop_evt = 1'b0;

    w_entry.data     = s_axis_tdata;
    w_entry.keep     = s_axis_tkeep;
    w_entry.last     = s_axis_tlast;
    w_entry.tid      = s_axis_tid;
    w_entry.port_sel = r_port_sel;
    w_entry.route    = r_route;

    unique case (r_state)
      ST_HEAD: begin
        if (w_s_hs) begin
          if (w_legal) begin
            w_push           = 1'b1;
            w_pkt_evt        = 1'b1;
            w_entry.port_sel = w_dec_sel;
            w_entry.route    = s_axis_tdest;
            if (!s_axis_tlast) w_state_n = ST_BODY;
          end else begin
            w_drop_evt = 1'b1;
            if (!s_axis_tlast) w_state_n = ST_DROP;
          end
        end
      end
      ST_BODY: begin
        // tdest on non-head beats is ignored; the latched route is used.
        if (w_s_hs) begin
          w_push = 1'b1;
          if (s_axis_tlast) w_state_n = ST_HEAD;
        end
      end
      ST_DROP: begin
        if (w_s_hs && s_axis_tlast) w_state_n = ST_HEAD;
      end
      default: w_state_n = ST_HEAD;
    endcase
  end

  always_comb begin
    w_count_n = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + 2'd1;
      2'b01:   w_count_n = r_count - 2'd1;
      default: w_count_n = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and latched route
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, whatever the block order.
    if (!aresetn) begin
      r_state    <= ST_HEAD;
      r_port_sel <= '0;
      r_route    <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_pkt_evt) begin
        r_port_sel <= w_dec_sel;
        r_route    <= s_axis_tdest;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid buffer. Upstream ready is a flop computed from the next
  // occupancy, so it never depends combinationally on m_axis_tready. In DROP
  // the stage always accepts because nothing is written to the buffer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: the two payload entries are reset too, because the output bus
      // reads straight from storage and must show zero after reset.
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= !r_rd_ptr;
      r_count   <= w_count_n;
      r_s_ready <= (w_state_n == ST_DROP) || (w_count_n != 2'd2);
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign m_axis_tdata = w_head.data;
  assign m_axis_tkeep = w_head.keep;
  assign m_axis_tlast = w_head.last;
  assign m_axis_tid   = w_head.tid;
  assign m_port_sel   = w_head.port_sel;
  assign m_route      = w_head.route;

  // ---------------------------------------------------------------------------
  // Statistics: separate saturating incrementers so a forward and a drop in
  // the same cycle both land.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pkt_cnt <= '0;
    end else if (w_pkt_evt && (r_pkt_cnt != {CNT_BITS{1'b1}})) begin
      r_pkt_cnt <= r_pkt_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_drop_cnt <= '0;
    end else if (w_drop_evt && (r_drop_cnt != {CNT_BITS{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_err_sticky <= 1'b0;
    end else if (w_drop_evt) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign pkt_cnt    = r_pkt_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign err_sticky = r_err_sticky;

`ifdef VIO_SENDER_CHECK_EN
  logic r_spoof_sticky;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_spoof_sticky <= 1'b0;
    end else if (w_drop_evt && w_spoof) begin
      r_spoof_sticky <= 1'b1;
    end
  end

  assign spoof_sticky = r_spoof_sticky;
`endif

endmodule

// File: tb/tb_vio_ingress_decode.sv
// -----------------------------------------------------------------------------
// Testbench for vio_ingress_decode (default parameters).
// Packets are driven from a table of {header tdest, body tdest, tid, length,
// expected forward/drop, expected port select}; forwarded beats are pushed to
// a scoreboard queue when accepted and compared when they leave the DUT.
// Hand-written sequences cover latency, back-to-back single beats, reset in
// the middle of a packet and the optional sender check.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vio_ingress_decode;

  localparam int N_PORTS   = 11;
  localparam int DATA_BITS = 512;
  localparam int PID_BITS  = 6;
  localparam int CNT_BITS  = 32;
  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int NV        = 10;

  typedef logic [DATA_BITS-1:0] wide_t;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
    logic [PID_BITS-1:0]  tid;
    logic [N_PORTS-1:0]   sel;
    logic [13:0]          route;
  } exp_beat_t;

  typedef struct {
    logic [13:0]         head;
    logic [13:0]         body;
    logic [PID_BITS-1:0] tid;
    int                  beats;
    logic                fwd;
    logic [N_PORTS-1:0]  sel;
  } pkt_vec_t;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [DATA_BITS-1:0] s_axis_tdata;
  logic [KEEP_BITS-1:0] s_axis_tkeep;
  logic                 s_axis_tlast;
  logic [PID_BITS-1:0]  s_axis_tid;
  logic [13:0]          s_axis_tdest;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [DATA_BITS-1:0] m_axis_tdata;
  logic [KEEP_BITS-1:0] m_axis_tkeep;
  logic                 m_axis_tlast;
  logic [PID_BITS-1:0]  m_axis_tid;
  logic [N_PORTS-1:0]   m_port_sel;
  logic [13:0]          m_route;
  logic [CNT_BITS-1:0]  pkt_cnt;
  logic [CNT_BITS-1:0]  drop_cnt;
  logic                 err_sticky;
`ifdef VIO_SENDER_CHECK_EN
  logic                 spoof_sticky;
`endif

  always #5 aclk = ~aclk;

  vio_ingress_decode #(
    .N_PORTS  (N_PORTS),
    .DATA_BITS(DATA_BITS),
    .PID_BITS (PID_BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tid   (s_axis_tid),
    .s_axis_tdest (s_axis_tdest),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_port_sel   (m_port_sel),
    .m_route      (m_route),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .err_sticky   (err_sticky)
`ifdef VIO_SENDER_CHECK_EN
    ,
    .spoof_sticky (spoof_sticky)
`endif
  );

  int        n_checks = 0;
  int        n_errors = 0;
  int        cyc      = 0;
  int        rdy_mode = 0;   // 0: m_axis_tready held high, 1: random
  int        beat_id  = 0;
  int        exp_pkt  = 0;
  int        exp_drop = 0;
  int        in_cyc_q[$];
  int        out_cyc_q[$];
  exp_beat_t sb[$];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready generator
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Drive one beat, wait (bounded) for the handshake, record the expectation.
  task automatic send_beat(input logic [13:0] tdest, input logic [PID_BITS-1:0] tid,
                           input logic last, input logic fwd,
                           input logic [N_PORTS-1:0] sel, input logic [13:0] route,
                           output int waits);
    exp_beat_t e;
    beat_id++;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {(DATA_BITS/32){beat_id}};
    s_axis_tkeep  = {$urandom, $urandom};
    s_axis_tlast  = last;
    s_axis_tid    = tid;
    s_axis_tdest  = tdest;
    waits = 0;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      waits++;
      if (waits > 500) break;
    end
    if (waits > 500) begin
      check("s_ready_timeout", wide_t'(s_axis_tready), wide_t'(1));
    end else begin
      in_cyc_q.push_back(cyc);
      if (fwd) begin
        e.data  = s_axis_tdata;
        e.keep  = s_axis_tkeep;
        e.last  = last;
        e.tid   = tid;
        e.sel   = sel;
        e.route = route;
        sb.push_back(e);
      end
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    check("drain", wide_t'(sb.size()), wide_t'(0));
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_s_ready", wide_t'(s_axis_tready), wide_t'(0));
    check("rst_m_valid", wide_t'(m_axis_tvalid), wide_t'(0));
    check("rst_m_data",  wide_t'(m_axis_tdata),  wide_t'(0));
    check("rst_port_sel", wide_t'(m_port_sel),   wide_t'(0));
    check("rst_route",   wide_t'(m_route),       wide_t'(0));
    check("rst_pkt_cnt", wide_t'(pkt_cnt),       wide_t'(0));
    check("rst_drop_cnt", wide_t'(drop_cnt),     wide_t'(0));
    check("rst_err",     wide_t'(err_sticky),    wide_t'(0));
`ifdef VIO_SENDER_CHECK_EN
    check("rst_spoof",   wide_t'(spoof_sticky),  wide_t'(0));
`endif
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_reset_state();
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  // Output monitor: scoreboard compare and hold-during-stall check
  exp_beat_t                               mon_e;
  logic                                    prev_stall = 1'b0;
  logic [DATA_BITS-1:0]                    held_data;
  logic [KEEP_BITS+PID_BITS+N_PORTS+14:0]  held_meta;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", wide_t'(m_axis_tvalid), wide_t'(1));
        check("stall_data", wide_t'(m_axis_tdata), wide_t'(held_data));
        check("stall_meta",
              wide_t'({m_axis_tkeep, m_axis_tlast, m_axis_tid, m_port_sel, m_route}),
              wide_t'(held_meta));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held_data  = m_axis_tdata;
      held_meta  = {m_axis_tkeep, m_axis_tlast, m_axis_tid, m_port_sel, m_route};
      if (m_axis_tvalid && m_axis_tready) begin
        out_cyc_q.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_beat", wide_t'(m_axis_tvalid), wide_t'(0));
        end else begin
          mon_e = sb.pop_front();
          check("out_data",     wide_t'(m_axis_tdata), wide_t'(mon_e.data));
          check("out_keep",     wide_t'(m_axis_tkeep), wide_t'(mon_e.keep));
          check("out_last",     wide_t'(m_axis_tlast), wide_t'(mon_e.last));
          check("out_tid",      wide_t'(m_axis_tid),   wide_t'(mon_e.tid));
          check("out_port_sel", wide_t'(m_port_sel),   wide_t'(mon_e.sel));
          check("out_route",    wide_t'(m_route),      wide_t'(mon_e.route));
        end
      end
    end
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_vec_t vec [NV];
    int       waits;
    int       span;

    vec[0] = '{14'h0070, 14'h0070, 6'd1, 4, 1'b0, 11'h000}; // receiver 12
    vec[1] = '{14'h0004, 14'h0008, 6'd0, 5, 1'b1, 11'h002}; // body tdest ignored
    vec[2] = '{14'h0404, 14'h0404, 6'd0, 2, 1'b0, 11'h000}; // reserved bit set
    vec[3] = '{14'h0088, 14'h0088, 6'd2, 1, 1'b0, 11'h000}; // self-loop
    vec[4] = '{14'h0028, 14'h0004, 6'd0, 2, 1'b1, 11'h400}; // receiver 10, last port
    vec[5] = '{14'h002C, 14'h002C, 6'd0, 1, 1'b0, 11'h000}; // receiver 11
    vec[6] = '{14'h00C3, 14'h3FFF, 6'd3, 3, 1'b1, 11'h001}; // flags passed through
    vec[7] = '{14'h0058, 14'h0058, 6'd1, 1, 1'b1, 11'h040};
    vec[8] = '{14'h0070, 14'h0070, 6'd1, 1, 1'b0, 11'h000}; // single-beat drop
    vec[9] = '{14'h0004, 14'h0004, 6'd0, 1, 1'b1, 11'h002}; // right after a drop

    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tid    = '0;
    s_axis_tdest  = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_state();
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // 3-beat packet to port 1, one-cycle latency
    rdy_mode = 0;
    @(negedge aclk);
    check("lat_pre_valid", wide_t'(m_axis_tvalid), wide_t'(0));
    @(posedge aclk);
    #1;
    send_beat(14'h0004, 6'd0, 1'b0, 1'b1, 11'h002, 14'h0004, waits);
    exp_pkt++;
    @(negedge aclk);
    check("lat_valid", wide_t'(m_axis_tvalid), wide_t'(1));
    @(posedge aclk);
    #1;
    send_beat(14'h0004, 6'd0, 1'b0, 1'b1, 11'h002, 14'h0004, waits);
    send_beat(14'h0004, 6'd0, 1'b1, 1'b1, 11'h002, 14'h0004, waits);
    wait_drain();
    check("t1_pkt_cnt", wide_t'(pkt_cnt), wide_t'(exp_pkt));

    // Table-driven packets under random back-pressure
    rdy_mode = 1;
    for (int p = 0; p < NV; p++) begin
      for (int b = 0; b < vec[p].beats; b++) begin
        send_beat((b == 0) ? vec[p].head : vec[p].body, vec[p].tid,
                  (b == vec[p].beats - 1), vec[p].fwd, vec[p].sel, vec[p].head, waits);
        if (!vec[p].fwd && b > 0) check("drop_ready", wide_t'(waits), wide_t'(0));
        if (b == 0) begin
          if (vec[p].fwd) exp_pkt++;
          else            exp_drop++;
        end
      end
      check("vec_pkt_cnt",  wide_t'(pkt_cnt),  wide_t'(exp_pkt));
      check("vec_drop_cnt", wide_t'(drop_cnt), wide_t'(exp_drop));
    end
    check("vec_err_sticky", wide_t'(err_sticky), wide_t'(1));
    wait_drain();

    // Back-to-back single-beat packets, no bubbles either side
    rdy_mode = 0;
    @(posedge aclk);
    #1;
    in_cyc_q.delete();
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_beat(14'h0058, 6'd1, 1'b1, 1'b1, 11'h040, 14'h0058, waits);
      exp_pkt++;
    end
    wait_drain();
    check("b2b_in_count", wide_t'(in_cyc_q.size()), wide_t'(8));
    check("b2b_out_count", wide_t'(out_cyc_q.size()), wide_t'(8));
    if (in_cyc_q.size() == 8 && out_cyc_q.size() == 8) begin
      span = in_cyc_q[7] - in_cyc_q[0];
      check("b2b_in_span", wide_t'(span), wide_t'(7));
      span = out_cyc_q[7] - out_cyc_q[0];
      check("b2b_out_span", wide_t'(span), wide_t'(7));
    end
    check("b2b_pkt_cnt", wide_t'(pkt_cnt), wide_t'(exp_pkt));

    // Reset in the middle of a packet; the next beat is a fresh header
    send_beat(14'h0004, 6'd0, 1'b0, 1'b1, 11'h002, 14'h0004, waits);
    send_beat(14'h0004, 6'd0, 1'b0, 1'b1, 11'h002, 14'h0004, waits);
    wait_drain();
    do_reset();
    exp_pkt  = 0;
    exp_drop = 0;
    send_beat(14'h000C, 6'd0, 1'b1, 1'b1, 11'h008, 14'h000C, waits);
    exp_pkt++;
    wait_drain();
    check("rst_next_pkt_cnt", wide_t'(pkt_cnt), wide_t'(exp_pkt));
    check("rst_next_err", wide_t'(err_sticky), wide_t'(0));

    // tid does not match the sender field of the route
`ifdef VIO_SENDER_CHECK_EN
    send_beat(14'h0004, 6'd1, 1'b0, 1'b0, 11'h000, 14'h0000, waits);
    send_beat(14'h0004, 6'd1, 1'b1, 1'b0, 11'h000, 14'h0000, waits);
    exp_drop++;
    check("spoof_sticky", wide_t'(spoof_sticky), wide_t'(1));
    check("spoof_err", wide_t'(err_sticky), wide_t'(1));
`else
    send_beat(14'h0004, 6'd1, 1'b0, 1'b1, 11'h002, 14'h0004, waits);
    send_beat(14'h0004, 6'd1, 1'b1, 1'b1, 11'h002, 14'h0004, waits);
    exp_pkt++;
`endif
    wait_drain();
    check("spoof_pkt_cnt",  wide_t'(pkt_cnt),  wide_t'(exp_pkt));
    check("spoof_drop_cnt", wide_t'(drop_cnt), wide_t'(exp_drop));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
